// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and RAM-side signals of the LSU data-RAM port.
// The slave modport is the LSU itself; the master modport is the core plus RAM environment.
interface lsu_mem_port_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_masking;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_w_en, mem_address, mem_masking, mem_write_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_w_en, mem_address, mem_masking, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit driving a 1-cycle registered, byte-masked data RAM.
// One request per handshake; misaligned or illegal accesses complete with rsp_err and never touch RAM.
module lsu_mem_port #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_port_if.slave  io_bus
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_READ   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state,          w_state_nxt;
    logic                r_we,             w_we_nxt;
    logic [2:0]          r_funct3,         w_funct3_nxt;
    logic [1:0]          r_addr_lo,        w_addr_lo_nxt;
    logic                r_req_ready,      w_req_ready_nxt;
    logic                r_rsp_valid,      w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata,      w_rsp_rdata_nxt;
    logic                r_rsp_err,        w_rsp_err_nxt;
    logic                r_mem_w_en,       w_mem_w_en_nxt;
    logic [ADDR_W-1:0]   r_mem_address,    w_mem_address_nxt;
    logic [3:0]          r_mem_masking,    w_mem_masking_nxt;
    logic [DATA_W-1:0]   r_mem_write_data, w_mem_write_data_nxt;

    logic                w_req_err;
    logic [3:0]          w_st_mask;
    logic [DATA_W-1:0]   w_st_data;
    logic [7:0]          w_ld_byte;
    logic [15:0]         w_ld_half;
    logic [DATA_W-1:0]   w_ld_data;
    logic                w_unused_addr;

    // Byte address bits above the RAM range wrap and are intentionally dropped.
    assign w_unused_addr = ^{io_bus.req_addr[31:ADDR_W+2]};

    // Alignment and funct3 legality of the incoming request.
    always_comb begin
        w_req_err = 1'b0;
        case (io_bus.req_funct3)
            3'b000:  w_req_err = 1'b0;
            3'b001:  w_req_err = io_bus.req_addr[0];
            3'b010:  w_req_err = |io_bus.req_addr[1:0];
            3'b100:  w_req_err = io_bus.req_we;
            3'b101:  w_req_err = io_bus.req_we | io_bus.req_addr[0];
            default: w_req_err = 1'b1;
        endcase
    end

    // Store lane mask and lane-replicated write data.
    always_comb begin
        w_st_mask = 4'b1111;
        w_st_data = io_bus.req_wdata;
        case (io_bus.req_funct3[1:0])
            2'b00: begin
                w_st_mask = 4'b0001 << io_bus.req_addr[1:0];
                w_st_data = {4{io_bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_mask = 4'b0011 << io_bus.req_addr[1:0];
                w_st_data = {2{io_bus.req_wdata[15:0]}};
            end
            default: begin
                w_st_mask = 4'b1111;
                w_st_data = io_bus.req_wdata;
            end
        endcase
    end

    // Load lane select and extension from the latched address and funct3.
    always_comb begin
        w_ld_byte = io_bus.mem_read_data[7:0];
        case (r_addr_lo)
            2'd0:    w_ld_byte = io_bus.mem_read_data[7:0];
            2'd1:    w_ld_byte = io_bus.mem_read_data[15:8];
            2'd2:    w_ld_byte = io_bus.mem_read_data[23:16];
            default: w_ld_byte = io_bus.mem_read_data[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? io_bus.mem_read_data[31:16] : io_bus.mem_read_data[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = io_bus.mem_read_data;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt          = r_state;
        w_we_nxt             = r_we;
        w_funct3_nxt         = r_funct3;
        w_addr_lo_nxt        = r_addr_lo;
        w_rsp_valid_nxt      = 1'b0;
        w_rsp_rdata_nxt      = r_rsp_rdata;
        w_rsp_err_nxt        = r_rsp_err;
        w_mem_w_en_nxt       = 1'b0;
        w_mem_address_nxt    = r_mem_address;
        w_mem_masking_nxt    = 4'b0000;
        w_mem_write_data_nxt = r_mem_write_data;

        case (r_state)
            S_IDLE: begin
                if (io_bus.req_valid) begin
                    w_we_nxt          = io_bus.req_we;
                    w_funct3_nxt      = io_bus.req_funct3;
                    w_addr_lo_nxt     = io_bus.req_addr[1:0];
                    w_mem_address_nxt = io_bus.req_addr[ADDR_W+1:2];
                    if (w_req_err) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_state_nxt = S_ACCESS;
                        if (io_bus.req_we) begin
                            w_mem_w_en_nxt       = 1'b1;
                            w_mem_masking_nxt    = w_st_mask;
                            w_mem_write_data_nxt = w_st_data;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (r_we) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt     = S_RESP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b0;
                w_rsp_rdata_nxt = w_ld_data;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_we             <= 1'b0;
            r_funct3         <= 3'd0;
            r_addr_lo        <= 2'd0;
            r_req_ready      <= 1'b1;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_err        <= 1'b0;
            r_mem_w_en       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_masking    <= 4'b0000;
            r_mem_write_data <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_we             <= w_we_nxt;
            r_funct3         <= w_funct3_nxt;
            r_addr_lo        <= w_addr_lo_nxt;
            r_req_ready      <= w_req_ready_nxt;
            r_rsp_valid      <= w_rsp_valid_nxt;
            r_rsp_rdata      <= w_rsp_rdata_nxt;
            r_rsp_err        <= w_rsp_err_nxt;
            r_mem_w_en       <= w_mem_w_en_nxt;
            r_mem_address    <= w_mem_address_nxt;
            r_mem_masking    <= w_mem_masking_nxt;
            r_mem_write_data <= w_mem_write_data_nxt;
        end
    end

    assign io_bus.req_ready      = r_req_ready;
    assign io_bus.rsp_valid      = r_rsp_valid;
    assign io_bus.rsp_rdata      = r_rsp_rdata;
    assign io_bus.rsp_err        = r_rsp_err;
    assign io_bus.mem_w_en       = r_mem_w_en;
    assign io_bus.mem_address    = r_mem_address;
    assign io_bus.mem_masking    = r_mem_masking;
    assign io_bus.mem_write_data = r_mem_write_data;

endmodule
